// File: rtl/dram_stream_reader.sv
// Streams a block of words from a 2-port distributed RAM as one
// AXI-Stream packet, with full backpressure at one word per cycle.
//
// Ports:
//   clk, reset       : clock, async active-high reset
//   start, stop      : command pulse (IDLE only) / abort (busy only)
//   base_addr, len_m1: first address and word count minus one
//   raddr, rdata     : RAM read address and combinational read data
//   o_tdata, o_tlast, o_tvalid, o_tready : AXI-Stream master
//   busy, done       : packet in flight / final word accepted pulse
//
// Optional feature macro: DRAM_STREAM_READER_LOOP_EN adds input `loop`;
// when captured high, the block repeats back-to-back until stop.

module dram_stream_reader #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
`ifdef DRAM_STREAM_READER_LOOP_EN
   input  logic              loop,
`endif
   input  logic [AWIDTH-1:0] base_addr,
   input  logic [AWIDTH-1:0] len_m1,
   output logic [AWIDTH-1:0] raddr,
   input  logic [DWIDTH-1:0] rdata,
   output logic [DWIDTH-1:0] o_tdata,
   output logic              o_tlast,
   output logic              o_tvalid,
   input  logic              o_tready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_LAST
   } state_t;

   state_t            r_state;
   logic [AWIDTH-1:0] r_raddr;
   logic [AWIDTH-1:0] r_count;
   logic [DWIDTH-1:0] r_tdata;
   logic              r_tlast;
   logic              r_tvalid;
   logic              r_busy;
   logic              r_done;
`ifdef DRAM_STREAM_READER_LOOP_EN
   logic [AWIDTH-1:0] r_base;
   logic [AWIDTH-1:0] r_len;
   logic              r_loop;
`endif

   // Output register can take a new word this cycle.
   logic w_adv;
   logic w_cnt_zero;

   assign w_adv      = !r_tvalid || o_tready;
   assign w_cnt_zero = (r_count == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_raddr  <= '0;
         r_count  <= '0;
         r_tdata  <= '0;
         r_tlast  <= 1'b0;
         r_tvalid <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef DRAM_STREAM_READER_LOOP_EN
         r_base   <= '0;
         r_len    <= '0;
         r_loop   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_raddr <= base_addr;
                  r_count <= len_m1;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
`ifdef DRAM_STREAM_READER_LOOP_EN
                  r_base  <= base_addr;
                  r_len   <= len_m1;
                  r_loop  <= loop;
`endif
               end
            end
            S_RUN: begin
               if (stop) begin
                  // Either tag the held word or load one final word,
                  // so the packet always ends with tlast.
                  if (w_adv) begin
                     r_tdata  <= rdata;
                     r_tvalid <= 1'b1;
                  end
                  r_tlast <= 1'b1;
                  r_state <= S_LAST;
               end else if (w_adv) begin
                  r_tdata  <= rdata;
                  r_tvalid <= 1'b1;
                  r_tlast  <= w_cnt_zero;
                  if (w_cnt_zero) begin
`ifdef DRAM_STREAM_READER_LOOP_EN
                     if (r_loop) begin
                        r_raddr <= r_base;
                        r_count <= r_len;
                     end else begin
                        r_state <= S_LAST;
                     end
`else
                     r_state <= S_LAST;
`endif
                  end else begin
                     r_raddr <= r_raddr + 1'b1;
                     r_count <= r_count - 1'b1;
                  end
               end
            end
            S_LAST: begin
               if (r_tvalid && o_tready) begin
                  r_tvalid <= 1'b0;
                  r_tlast  <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign raddr    = r_raddr;
   assign o_tdata  = r_tdata;
   assign o_tlast  = r_tlast;
   assign o_tvalid = r_tvalid;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: doc/dram_stream_reader.md
Name: dram_stream_reader

Overview:
- Reader side for a 2-port distributed RAM: drives the RAM's read address and samples its combinational read data.
- On a start command, emits a block of words as one AXI-Stream packet, from a base address for a given length.
- Sits between a waveform/sample buffer RAM (filled by a separate writer) and a downstream AXI-Stream consumer; full backpressure, 1 word/cycle sustained.

Parameters:
DWIDTH, 32, data word width (matches RAM data width)
AWIDTH, 9, RAM address width; RAM depth is 2^AWIDTH

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle command pulse; sampled only in IDLE
stop  input  1  abort request; sampled only when busy
base_addr  input  AWIDTH  first RAM address, captured on accepted start
len_m1  input  AWIDTH  packet length minus one (0 => 1 word, all-ones => 2^AWIDTH words), captured on accepted start
raddr  output  AWIDTH  RAM read address (to RAM raddr)
rdata  input  DWIDTH  RAM combinational read data for raddr
o_tdata  output  DWIDTH  stream data
o_tlast  output  1  last word of packet
o_tvalid  output  1  stream valid
o_tready  input  1  stream ready
busy  output  1  high from accepted start until final word accepted
done  output  1  one-cycle pulse when final word accepted (normal or aborted)

Behaviour:
- Reset (async assert, sync release): state=IDLE; raddr=0, o_tdata=0, o_tlast=0, o_tvalid=0, busy=0, done=0; word counter=0.
- States: IDLE, RUN, LAST.
- IDLE: start=1 -> capture base_addr/len_m1, raddr<=base_addr, count<=len_m1, busy<=1, go RUN. stop ignored in IDLE; start+stop same cycle => start accepted, stop ignored.
- Output register "empty-or-accepted" = !o_tvalid || o_tready. In RUN, on each such cycle: o_tdata<=rdata, o_tvalid<=1, o_tlast<=(count==0), raddr<=raddr+1 (mod 2^AWIDTH), count<=count-1. If count==0, go LAST.
- Latency: start accepted in cycle N -> o_tvalid=1 with word RAM[base_addr] in cycle N+2 (N+1 drives raddr, N+2 registers data). No bubbles while o_tready=1.
- AXI rules: once o_tvalid=1, o_tdata/o_tlast are held stable until o_tready=1. A handshake with o_tlast=1 ends the packet.
- LAST: wait for o_tready while o_tvalid=1. On handshake: o_tvalid<=0, o_tlast<=0, busy<=0, done<=1 for one cycle, go IDLE.
- stop while busy (RUN):
  - If a word is held (o_tvalid=1 and not accepted this cycle), force o_tlast<=1 on it and go LAST; no further RAM reads.
  - If the output register is empty or being accepted this cycle, load one final word with o_tlast=1 and go LAST, so the packet is always tlast-terminated.
- stop in LAST is ignored.
- start while busy is ignored; no queuing.
- Address wraps mod 2^AWIDTH: base_addr=2^AWIDTH-2, len_m1=3 reads addrs 510,511,0,1 (AWIDTH=9).
- Reset asserted mid-packet: all outputs clear immediately; no done pulse; no tlast is emitted.
- RAM writes to addresses not yet read are visible in the stream; no coherency guarantee beyond that.

Optional Feature:
- Macro: DRAM_STREAM_READER_LOOP_EN.
- Defined:
  - Adds input port `loop` (1 bit), captured with start.
  - If captured loop=1, reaching count==0 in RUN still sets o_tlast=1 on that word, but the block reloads raddr<=base_addr and count<=len_m1 and stays in RUN.
  - Result: back-to-back repeated packets with no idle cycle, until stop. stop then terminates as above.
  - done pulses only at final termination.
- Not defined: no `loop` port; single packet per start.

Test Plan:
- RAM preloaded RAM[a]=a+0x100; start base=4, len_m1=3, o_tready=1 -> o_tvalid at N+2, data 0x104,0x105,0x106,0x107 on consecutive cycles; tlast on 0x107; done one cycle after; busy low.
- Same command with o_tready toggling 1,0,0,1,0,1... -> identical data order; tdata/tlast stable while stalled; no duplicates or drops.
- Wrap: base=510, len_m1=3 (AWIDTH=9) -> 0x2FE,0x2FF,0x100,0x101. len_m1=0 -> single word with tlast=1.
- stop during run, base=0, len_m1=15, o_tready=0 at word 3 held: stop pulses -> word 3 gets tlast=1; no further words; done on its acceptance. start during busy -> ignored.
- Async reset asserted mid-packet between clock edges -> o_tvalid/busy drop without clock edge; after release, a new start streams correctly from its new base.
- LOOP_EN: base=8, len_m1=1, loop=1 -> 0x108,0x109(tlast),0x108,0x109(tlast)... gapless; stop -> current word tlast, done once.
